// File: rtl/b_frag_cfg_seq.sv
// b_frag_cfg_seq
// Holds a shadow copy of the B_FRAG inverter configuration (4 bits per slot)
// and, on COMMIT, shifts a snapshot of it onto the serial config chain MSB
// first, captures the chain tail into a readback register, then strobes SLD.
//
// Ports
//   QCK       clock, rising edge
//   QRT       synchronous active-high reset
//   CFG_VLD   slot write request          CFG_IDX  slot index
//   CFG_BITS  {XBS2,XBS1,XAS2,XAS1}       CFG_RDY  write accepted (IDLE only)
//   COMMIT    start shifting the shadow array onto the chain
//   SEN/SDO   chain shift enable / serial data out
//   SDI       chain tail return, sampled while SEN=1
//   SLD       one-cycle latch strobe      DONE     one-cycle completion pulse
//   BUSY      sequence in progress (through the SLD cycle)
//   RB_IDX    readback slot select        RB_BITS  readback slot contents
module b_frag_cfg_seq #(
    parameter int N_FRAG = 8
) (
    input  logic                      QCK,
    input  logic                      QRT,
    input  logic                      CFG_VLD,
    input  logic [$clog2(N_FRAG)-1:0] CFG_IDX,
    input  logic [3:0]                CFG_BITS,
    output logic                      CFG_RDY,
    input  logic                      COMMIT,
    output logic                      SEN,
    output logic                      SDO,
    input  logic                      SDI,
    output logic                      SLD,
    output logic                      DONE,
    output logic                      BUSY,
    input  logic [$clog2(N_FRAG)-1:0] RB_IDX,
    output logic [3:0]                RB_BITS
);

    localparam int IDX_W = $clog2(N_FRAG);
    localparam int W     = 4 * N_FRAG;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    // Slot s bit b lives at flat index 4*s+b, so shift cycle k maps to
    // flat index W-1-k and the stream is simply the flat vector MSB first.
    logic [W-1:0]     shadow, shadow_nx;
    logic [W-1:0]     snap, snap_nx;
    logic [W-1:0]     rb, rb_nx;
    logic             rdy_nx, sen_nx, sdo_nx, sld_nx, done_nx, busy_nx;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        snap_nx   = snap;
        rb_nx     = rb;
        rdy_nx    = 1'b0;
        sen_nx    = 1'b0;
        sdo_nx    = 1'b0;
        sld_nx    = 1'b0;
        done_nx   = 1'b0;
        busy_nx   = BUSY;
        case (state)
            IDLE: begin
                rdy_nx = 1'b1;
                // Out-of-range indices match no slot and are silently dropped.
                if (CFG_VLD && CFG_RDY) begin
                    for (int unsigned i = 0; i < N_FRAG; i++) begin
                        if (CFG_IDX == IDX_W'(i)) begin
                            shadow_nx[4*i +: 4] = CFG_BITS;
                        end
                    end
                end
                // Snapshot uses shadow_nx so a same-cycle write is streamed.
                // The first bit goes straight to SDO; snap keeps the rest
                // MSB-aligned.
                if (COMMIT) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                    sdo_nx   = shadow_nx[W-1];
                    snap_nx  = {shadow_nx[W-2:0], 1'b0};
                    sen_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    rdy_nx   = 1'b0;
                end
            end
            SHIFT: begin
                rb_nx = {rb[W-2:0], SDI};
                if (cnt == LAST) begin
                    state_nx = LATCH;
                    cnt_nx   = '0;
                    sld_nx   = 1'b1;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx  = cnt + 1'b1;
                    sen_nx  = 1'b1;
                    sdo_nx  = snap[W-1];
                    snap_nx = {snap[W-2:0], 1'b0};
                end
            end
            LATCH: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                rdy_nx   = 1'b1;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state   <= IDLE;
            cnt     <= '0;
            shadow  <= '0;
            snap    <= '0;
            rb      <= '0;
            CFG_RDY <= 1'b0;
            SEN     <= 1'b0;
            SDO     <= 1'b0;
            SLD     <= 1'b0;
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            shadow  <= shadow_nx;
            snap    <= snap_nx;
            rb      <= rb_nx;
            CFG_RDY <= rdy_nx;
            SEN     <= sen_nx;
            SDO     <= sdo_nx;
            SLD     <= sld_nx;
            DONE    <= done_nx;
            BUSY    <= busy_nx;
        end
    end

    always_comb begin
        RB_BITS = '0;
        for (int unsigned i = 0; i < N_FRAG; i++) begin
            if (RB_IDX == IDX_W'(i)) begin
                RB_BITS = rb[4*i +: 4];
            end
        end
    end

endmodule

// File: tb/tb_b_frag_cfg_seq.sv
// Testbench for b_frag_cfg_seq: a slot-level reference model predicts the
// serial stream, DONE timing, handshake and readback; monitors compare on
// the falling edge. A second instance (N_FRAG=6) covers out-of-range writes.
module tb_b_frag_cfg_seq;

    localparam int NF  = 8;
    localparam int W   = 4 * NF;
    localparam int IW  = 3;
    localparam int NF2 = 6;
    localparam int W2  = 4 * NF2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          qrt, cfg_vld, cfg_rdy, commit, sen, sdo, sdi, sld, done, busy;
    logic [IW-1:0] cfg_idx, rb_idx;
    logic [3:0]    cfg_bits, rb_bits;

    logic          qrt2, cfg_vld2, cfg_rdy2, commit2, sen2, sdo2, sdi2, sld2, done2, busy2;
    logic [2:0]    cfg_idx2, rb_idx2;
    logic [3:0]    cfg_bits2, rb_bits2;

    b_frag_cfg_seq #(.N_FRAG(NF)) dut (
        .QCK(clk), .QRT(qrt), .CFG_VLD(cfg_vld), .CFG_IDX(cfg_idx),
        .CFG_BITS(cfg_bits), .CFG_RDY(cfg_rdy), .COMMIT(commit), .SEN(sen),
        .SDO(sdo), .SDI(sdi), .SLD(sld), .DONE(done), .BUSY(busy),
        .RB_IDX(rb_idx), .RB_BITS(rb_bits)
    );

    b_frag_cfg_seq #(.N_FRAG(NF2)) dut2 (
        .QCK(clk), .QRT(qrt2), .CFG_VLD(cfg_vld2), .CFG_IDX(cfg_idx2),
        .CFG_BITS(cfg_bits2), .CFG_RDY(cfg_rdy2), .COMMIT(commit2), .SEN(sen2),
        .SDO(sdo2), .SDI(sdi2), .SLD(sld2), .DONE(done2), .BUSY(busy2),
        .RB_IDX(rb_idx2), .RB_BITS(rb_bits2)
    );

    // External loop-back chain: tail feeds SDI, SDO enters at the head.
    logic [W-1:0] chain;
    logic         ld;
    logic [W-1:0] ld_val;
    assign sdi = chain[W-1];
    always @(posedge clk) begin
        if (ld) chain <= ld_val;
        else if (sen) chain <= {chain[W-2:0], sdo};
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model (main instance) ----------------
    logic [3:0] m_sh   [NF];
    logic [3:0] exp_rb [NF];
    bit         exp_sdo[$];
    int         exp_done[$];
    bit         active  = 1'b0;
    int         a_st    = 0;
    int         rst_cyc = -1;

    // Stream position k carries slot NF-1-k/4, bit 3-k%4.
    function automatic logic [IW-1:0] slot_of(input int k);
        return IW'(NF - 1 - k / 4);
    endfunction
    function automatic logic [1:0] bit_of(input int k);
        return 2'(3 - k % 4);
    endfunction

    function automatic bit in_shift(input int c);
        return active && c >= a_st && c < a_st + W;
    endfunction
    function automatic bit busy_m(input int c);
        return active && c >= a_st && c <= a_st + W;
    endfunction
    function automatic bit idle_m(input int c);
        return !busy_m(c);
    endfunction
    function automatic bit rdy_m(input int c);
        return idle_m(c) && c != rst_cyc;
    endfunction

    initial begin
        int c;
        int k;
        forever begin
            @(posedge clk);
            c = cyc;
            if (qrt) begin
                exp_sdo.delete();
                exp_done.delete();
                for (int i = 0; i < NF; i++) begin
                    m_sh[i]   = '0;
                    exp_rb[i] = '0;
                end
                active  = 1'b0;
                rst_cyc = c + 1;
            end else begin
                if (in_shift(c)) begin
                    k = c - a_st;
                    exp_rb[slot_of(k)][bit_of(k)] = sdi;
                end
                if (cfg_vld && rdy_m(c)) m_sh[cfg_idx] = cfg_bits;
                if (commit && idle_m(c)) begin
                    for (int j = 0; j < W; j++) exp_sdo.push_back(m_sh[slot_of(j)][bit_of(j)]);
                    exp_done.push_back(c + 1 + W);
                    a_st   = c + 1;
                    active = 1'b1;
                end
            end
            cyc = c + 1;
        end
    end

    // ---------------- monitor (main instance) ----------------
    initial begin
        int c;
        forever begin
            @(negedge clk);
            c = cyc;
            chk("sen", 32'(sen), 32'(in_shift(c)));
            if (sen) begin
                if (exp_sdo.size() == 0) flag("sdo_unexpected_bit", 1, 0);
                else chk("sdo", 32'(sdo), 32'(exp_sdo.pop_front()));
            end else begin
                chk("sdo_idle", 32'(sdo), 0);
            end
            if (exp_done.size() > 0 && c > exp_done[0]) begin
                flag("done_missing", 0, exp_done[0]);
                void'(exp_done.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) flag("done_unexpected", 1, 0);
                else chk("done_cycle", c, exp_done.pop_front());
            end
            chk("sld_eq_done", 32'(sld), 32'(done));
            chk("busy", 32'(busy), 32'(busy_m(c)));
            chk("cfg_rdy", 32'(cfg_rdy), 32'(rdy_m(c)));
            if (idle_m(c)) chk("rb_bits", 32'(rb_bits), 32'(exp_rb[rb_idx]));
        end
    end

    // ---------------- scoreboard for the N_FRAG=6 instance ----------------
    logic [3:0] m2[NF2];
    bit         q2[$];
    int         done2_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (sen2) begin
                if (q2.size() == 0) flag("sdo2_unexpected_bit", 1, 0);
                else chk("sdo2", 32'(sdo2), 32'(q2.pop_front()));
            end else begin
                chk("sdo2_idle", 32'(sdo2), 0);
            end
            if (done2) done2_cnt++;
            chk("sld2_eq_done2", 32'(sld2), 32'(done2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [IW-1:0] idx, input logic [3:0] bits);
        cfg_vld  = 1'b1;
        cfg_idx  = idx;
        cfg_bits = bits;
        tick();
        cfg_vld  = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic write2(input logic [2:0] idx, input logic [3:0] bits);
        cfg_vld2  = 1'b1;
        cfg_idx2  = idx;
        cfg_bits2 = bits;
        if (int'(idx) < NF2) m2[idx] = bits;
        tick();
        cfg_vld2  = 1'b0;
    endtask

    task automatic commit2_push();
        for (int k = 0; k < W2; k++) q2.push_back(m2[3'(NF2 - 1 - k / 4)][2'(3 - k % 4)]);
        commit2 = 1'b1;
        tick();
        commit2 = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pre;
        qrt = 1'b1; cfg_vld = 1'b0; cfg_idx = '0; cfg_bits = '0; commit = 1'b0; rb_idx = '0;
        ld = 1'b1; ld_val = W'($urandom());
        qrt2 = 1'b1; cfg_vld2 = 1'b0; cfg_idx2 = '0; cfg_bits2 = '0; commit2 = 1'b0;
        rb_idx2 = '0; sdi2 = 1'b0;
        for (int i = 0; i < NF2; i++) m2[i] = '0;

        repeat (3) tick();
        ld = 1'b0;
        chk("rst_sen", 32'(sen), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_rdy", 32'(cfg_rdy), 0);
        qrt = 1'b0;
        tick();
        chk("rdy_after_reset", 32'(cfg_rdy), 1);

        // Basic load: slot 7 = 1000, slot 0 = 0001.
        write_cfg(3'd7, 4'b1000);
        write_cfg(3'd0, 4'b0001);
        do_commit();
        repeat (W + 4) tick();

        // Readback through a preloaded loop-back chain.
        pre = 32'hA5A5_A5A5;
        ld = 1'b1; ld_val = pre;
        tick();
        ld = 1'b0;
        do_commit();
        repeat (W + 4) tick();
        for (int s = 0; s < NF; s++) begin
            rb_idx = IW'(s);
            #1;
            chk("rb_preload", 32'(rb_bits), 32'(pre[4*s +: 4]));
        end

        // Write and COMMIT in one cycle, then requests during shift cycle 10.
        cfg_vld = 1'b1; cfg_idx = 3'd3; cfg_bits = 4'hF; commit = 1'b1;
        tick();
        cfg_vld = 1'b0; commit = 1'b0;
        repeat (10) tick();
        cfg_vld = 1'b1; cfg_idx = 3'd3; cfg_bits = 4'h0; commit = 1'b1;
        chk("rdy_during_shift", 32'(cfg_rdy), 0);
        tick();
        cfg_vld = 1'b0; commit = 1'b0;
        repeat (W) tick();
        do_commit();
        repeat (W + 4) tick();

        // Reset in shift cycle 20.
        do_commit();
        repeat (20) tick();
        qrt = 1'b1;
        tick();
        qrt = 1'b0;
        chk("sen_after_abort", 32'(sen), 0);
        tick();
        chk("rdy_after_abort", 32'(cfg_rdy), 1);
        repeat (W + 4) tick();
        for (int s = 0; s < NF; s++) begin
            rb_idx = IW'(s);
            #1;
            chk("rb_cleared", 32'(rb_bits), 0);
        end

        // Randomised traffic.
        repeat (400) begin
            qrt      = ($urandom_range(0, 199) == 0);
            commit   = ($urandom_range(0, 15) == 0);
            cfg_vld  = 1'($urandom_range(0, 1));
            cfg_idx  = IW'($urandom());
            cfg_bits = 4'($urandom());
            rb_idx   = IW'($urandom());
            tick();
        end
        qrt = 1'b0; commit = 1'b0; cfg_vld = 1'b0;
        repeat (W + 6) tick();
        chk("sdo_queue_drained", exp_sdo.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);

        // N_FRAG=6: out-of-range writes, then a real load.
        qrt2 = 1'b0;
        tick();
        tick();
        chk("rdy2", 32'(cfg_rdy2), 1);
        write2(3'd7, 4'hF);
        write2(3'd6, 4'hF);
        commit2_push();
        repeat (W2 + 4) tick();
        chk("done2_count_a", done2_cnt, 1);
        chk("q2_drained_a", q2.size(), 0);
        write2(3'd5, 4'h9);
        write2(3'd0, 4'h3);
        commit2_push();
        repeat (W2 + 4) tick();
        chk("done2_count_b", done2_cnt, 2);
        chk("q2_drained_b", q2.size(), 0);
        chk("busy2_idle", 32'(busy2), 0);
        chk("rb2_zero", 32'(rb_bits2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/b_frag_cfg_seq.md
B_FRAG_CFG_SEQ -- requirements
Module: b_frag_cfg_seq

Interface
REQ-001 SHALL have parameter N_FRAG, default 8, range 2..64: number of B_FRAG inverter-config slots on the serial chain.
REQ-002 SHALL have port QCK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port QRT  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port CFG_VLD  input  1  write request for one slot.
REQ-005 SHALL have port CFG_IDX  input  clog2(N_FRAG)  slot index to write.
REQ-006 SHALL have port CFG_BITS  input  4  inverter bits: [0]=XAS1, [1]=XAS2, [2]=XBS1, [3]=XBS2.
REQ-007 SHALL have port CFG_RDY  output  1  write accepted this cycle when CFG_VLD=1.
REQ-008 SHALL have port COMMIT  input  1  request to shift all shadow slots onto the chain.
REQ-009 SHALL have port SEN  output  1  shift enable to the chain.
REQ-010 SHALL have port SDO  output  1  serial data to the chain; valid when SEN=1.
REQ-011 SHALL have port SDI  input  1  chain tail return; sampled when SEN=1.
REQ-012 SHALL have port SLD  output  1  one-cycle latch strobe applying the shifted bits.
REQ-013 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-014 SHALL have port BUSY  output  1  high from the cycle after an accepted COMMIT through the SLD cycle.
REQ-015 SHALL have port RB_IDX  input  clog2(N_FRAG)  readback slot select.
REQ-016 SHALL have port RB_BITS  output  4  slot RB_IDX of the readback register, combinational from RB_IDX.
REQ-017 SHALL register all outputs except RB_BITS.

Function
REQ-018 SHALL hold a 4xN_FRAG shadow array; an accepted write (CFG_VLD & CFG_RDY) stores CFG_BITS into slot CFG_IDX at that edge.
REQ-019 SHALL drive CFG_RDY=1 only in state IDLE; writes with CFG_RDY=0 are dropped.
REQ-020 SHALL ignore a CFG_IDX >= N_FRAG; no slot changes, and CFG_RDY still reads 1.
REQ-021 SHALL implement states IDLE, SHIFT, LATCH, with transitions IDLE->SHIFT on COMMIT=1, SHIFT->LATCH after 4*N_FRAG shift cycles, and LATCH->IDLE after one cycle.
REQ-022 SHALL ignore COMMIT outside IDLE; it is not queued.
REQ-023 SHALL, when a write and COMMIT occur in the same IDLE cycle, include the written value in the shifted stream.
REQ-024 SHALL assert SEN for exactly 4*N_FRAG consecutive cycles, starting the cycle after COMMIT is accepted.
REQ-025 SHALL order the stream as follows: shift cycle k (0-based) carries slot N_FRAG-1-(k/4), bit 3-(k mod 4); the first bit out is slot N_FRAG-1 XBS2, and the last is slot 0 XAS1.
REQ-026 SHALL snapshot the shadow array at COMMIT acceptance; SDO follows the snapshot.
REQ-027 SHALL store the SDI value sampled in shift cycle k into the readback position mapped to k by REQ-025.
REQ-028 SHALL assert SLD and DONE together for one cycle, the cycle after the last SEN cycle; SEN=0 during that cycle.
REQ-029 SHALL size the shift counter as clog2(4*N_FRAG) bits, wrap it to 0 on entry to LATCH, and never let it exceed 4*N_FRAG-1.
REQ-030 SHALL give COMMIT-to-DONE latency of 4*N_FRAG+1 cycles.
REQ-031 SHALL hold SDO=0 whenever SEN=0.

Reset
REQ-032 SHALL, while QRT=1 at a clock edge, force state IDLE, counter 0, shadow, snapshot and readback all 0, and SEN=SDO=SLD=DONE=BUSY=0.
REQ-033 SHALL drive CFG_RDY=0 while QRT=1, and CFG_RDY=1 from the first edge after QRT falls.
REQ-034 SHALL abort a SHIFT in progress when QRT=1: no SLD and no DONE are issued, and readback is cleared.
REQ-035 SHALL give QRT priority over COMMIT and CFG_VLD in the same cycle.

Verification
REQ-036 SHALL cover basic load (N_FRAG=8): write slot 7=4'b1000 and slot 0=4'b0001, then COMMIT -> SEN high for 32 cycles, SDO=1 in cycles 0 and 31 only, SLD=DONE=1 in cycle 33 after COMMIT.
REQ-037 SHALL cover readback: an external 32-bit loop-back chain preloaded with 32'hA5A5_A5A5 returns its bits in order on SDI -> after DONE, RB_BITS for each slot matches the preload under the REQ-025 mapping.
REQ-038 SHALL cover a write and COMMIT in the same cycle: write slot 3=4'hF with COMMIT=1 -> SDO=1 in shift cycles 16..19.
REQ-039 SHALL cover requests during a shift: CFG_VLD and COMMIT pulsed in cycle 10 of SHIFT -> CFG_RDY=0, shadow unchanged, exactly one DONE.
REQ-040 SHALL cover reset mid-shift: QRT=1 in shift cycle 20 -> SEN=0 next cycle, no SLD/DONE ever issued, RB_BITS=0 for all slots, CFG_RDY=1 one cycle after QRT falls.
REQ-041 SHALL cover an out-of-range write: with N_FRAG=6, CFG_IDX=7 -> no slot changes, and a subsequent COMMIT streams 24 zero bits.
